cia_sub_pipe: RTL and testbench
===============================

// Module: cia_sub_pipe
// PURPOSE
//   Two-stage pipelined carry-increment subtractor: diff = a - b - bin, using the
//   group-carry chain of the carry-increment adder run as a + ~b + ~bin.
//   It complements the group-carry (gray-cell) adder datapath.
//   It sits between a valid/ready producer and consumer in the arithmetic datapath.
//   Full throughput: one result per cycle. Backpressure stalls both stages.
// PARAMETERS
//   N  16  operand/result width in bits; must be a multiple of V
//   V  4   carry-increment group size in bits; number of groups G = N/V
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands a/b/bin are valid
//   in_ready   out  1  block accepts operands this cycle
//   a          in   N  minuend (unsigned or two's complement)
//   b          in   N  subtrahend
//   bin        in   1  borrow in
//   out_valid  out  1  diff/bout/ovf are valid
//   out_ready  in   1  consumer accepts the result this cycle
//   diff       out  N  (a - b - bin) mod 2^N
//   bout       out  1  borrow out: 1 iff a < b + bin (unsigned)
//   ovf        out  1  signed overflow of a - b - bin
// BEHAVIOUR
//   Reset (async, rst_n=0): s1_v=0, s2_v=0, out_valid=0, diff=0, bout=0, ovf=0;
//     in_ready=1 one cycle after release. Any in-flight operation is discarded.
//   Handshake: input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
//     s2_adv = !s2_v | out_ready;  in_ready = !s1_v | s2_adv (comb path from out_ready).
//     out_valid = s2_v. Stage registers load only when their stage advances.
//     While out_valid=1 and out_ready=0, diff/bout/ovf hold stable.
//   Stage 1 (on accept): bb = ~b. For each group k: sum0[k] = a[k]+bb[k] with carry-in 0,
//     which gives V bits plus generate g[k] = that sum's carry-out and p[k] = &(a[k]^bb[k]).
//     Group 0 uses the real carry-in c_in = ~bin. Register sum0, g, p, and the sign bits
//     a[N-1] and bb[N-1].
//   Stage 2: serial group-carry chain c[k] = g[k] | (p[k] & c[k-1]), with c[-1] = ~bin
//     already folded into group 0. diff group k = sum0[k] + c[k-1] (increment, mod 2^V).
//     bout = ~c[G-1]. ovf = (a[N-1] == bb[N-1]) & (diff[N-1] != a[N-1]).
//   Latency: an accepted operand appears on out_valid exactly 2 cycles later if never
//     stalled. Order is preserved, with no drops and no duplicates.
//   Simultaneous accept + output drain in one cycle: both happen, throughput 1/cycle.
//   Capacity: 2 operations in flight. With out_ready=0, at most 2 accepts occur before
//     in_ready=0.
//   Boundaries: V==N gives G=1, a single group with no chain. V==1 gives a pure ripple
//     chain. N%V!=0 is an elaboration error ($error in generate).
//   in_valid while in_ready=0: no transfer. The producer must hold its data.
// TESTING
//   N=16,V=4: a=0x0000,b=0x0001,bin=0 -> diff=0xFFFF,bout=1,ovf=0 after 2 cycles.
//   a=0x8000,b=0x0001,bin=0 -> diff=0x7FFF,bout=0,ovf=1.
//   a=0x1234,b=0x1233,bin=1 -> diff=0x0000,bout=0,ovf=0. Tests the full group-propagate chain.
//   Hold out_ready=0 and offer 3 operands -> 2 accepted, then in_ready=0 and diff stable.
//     Release -> results come out in order.
//   Back-to-back: 100 random operands with out_ready=1 -> one result/cycle, each
//     matching the model {bout,diff} = {1'b0,a}-{1'b0,b}-bin (bout = bit N).
//   Assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately and no stale result
//     after release. Also sweep V=1,2,8,16 with N=16.

Source files
------------

// File: rtl/cia_sub_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined carry-increment subtractor.
// master drives operands and out_ready; slave is the subtractor itself.
interface cia_sub_pipe_if #(parameter int N = 16);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/cia_sub_pipe.sv
// Two-stage carry-increment subtractor: diff = a - b - bin computed as a + ~b + ~bin.
// Stage 1 forms per-group sums/generate/propagate; stage 2 runs the group carry chain.
module cia_sub_pipe #(
  parameter int N = 16,
  parameter int V = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cia_sub_pipe_if.slave   bus
);
  localparam int G  = N / V;
  localparam int VP = V + 1;

  if (N % V != 0) begin : g_bad_v
    $error("cia_sub_pipe: N (%0d) must be a multiple of V (%0d)", N, V);
  end

  // ---------------- handshake ----------------
  logic       r_rdy_en;
  logic [2:1] r_vld_pipe;
  logic       w_s1_adv, w_s2_adv, w_in_ready, w_acc;

  assign w_s2_adv   = !r_vld_pipe[2] | bus.out_ready;
  assign w_s1_adv   = !r_vld_pipe[1] | w_s2_adv;
  // Hold off the producer for the first cycle after reset release.
  assign w_in_ready = r_rdy_en & w_s1_adv;
  assign w_acc      = bus.in_valid & w_in_ready;

  // ---------------- stage 1: per-group sums ----------------
  logic [N-1:0]          w_bb;
  logic [G-1:0][V-1:0]   w_s0;
  logic [G-1:0]          w_g, w_p;

  assign w_bb = ~bus.b;

  for (genvar k = 0; k < G; k++) begin : g_grp
    logic [V-1:0] w_ak, w_bk;
    logic         w_ci;
    assign w_ak = bus.a[k*V +: V];
    assign w_bk = w_bb[k*V +: V];
    // Only group 0 sees the true carry-in; the others assume zero and get incremented later.
    assign w_ci = (k == 0) ? ~bus.bin : 1'b0;
    assign {w_g[k], w_s0[k]} = {1'b0, w_ak} + {1'b0, w_bk} + VP'(w_ci);
    assign w_p[k] = &(w_ak ^ w_bk);
  end

  logic [G-1:0][V-1:0]   r_s0;
  logic [G-1:0]          r_g, r_p;
  logic                  r_sa, r_sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en      <= 1'b0;
      r_vld_pipe[1] <= 1'b0;
      r_s0          <= '0;
      r_g           <= '0;
      r_p           <= '0;
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_s1_adv) r_vld_pipe[1] <= w_acc;
      if (w_acc) begin
        r_s0 <= w_s0;
        r_g  <= w_g;
        r_p  <= w_p;
        r_sa <= bus.a[N-1];
        r_sb <= w_bb[N-1];
      end
    end
  end

  // ---------------- stage 2: group carry chain + increment ----------------
  // w_c[k] is the carry into group k; w_c[0] is zero because ~bin is already in group 0.
  logic [G:0]   w_c;
  logic [N-1:0] w_diff;
  logic         w_bout, w_ovf;

  assign w_c[0] = 1'b0;

  for (genvar k = 0; k < G; k++) begin : g_chain
    assign w_c[k+1]           = r_g[k] | (r_p[k] & w_c[k]);
    assign w_diff[k*V +: V]   = r_s0[k] + V'(w_c[k]);
  end

  assign w_bout = ~w_c[G];
  assign w_ovf  = (r_sa == r_sb) & (w_diff[N-1] != r_sa);

  logic [N-1:0] r_diff;
  logic         r_bout, r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_diff        <= '0;
      r_bout        <= 1'b0;
      r_ovf         <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        r_diff <= w_diff;
        r_bout <= w_bout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_pipe[2];
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cia_sub_pipe.sv
// Bench for cia_sub_pipe: five instances (V=4,1,2,8,16 at N=16) driven in lockstep
// and checked against an arithmetic reference plus a capacity-2 in-order queue model.
module tb_cia_sub_pipe;
  localparam int N  = 16;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, bin = 1'b0, out_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;

  logic [ND-1:0]        rdy, ov, bo, of;
  logic [ND-1:0][N-1:0] df;

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int VK = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : 16;
    cia_sub_pipe_if #(.N(N)) ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.a         = a;
    assign ifc.b         = b;
    assign ifc.bin       = bin;
    assign ifc.out_ready = out_ready;
    assign rdy[k] = ifc.in_ready;
    assign ov[k]  = ifc.out_valid;
    assign df[k]  = ifc.diff;
    assign bo[k]  = ifc.bout;
    assign of[k]  = ifc.ovf;
    cia_sub_pipe #(.N(N), .V(VK)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  end

  typedef struct { logic [N-1:0] d; logic bo; logic ov; } res_t;
  typedef struct { res_t r; int age; } item_t;
  typedef struct { logic [N-1:0] a, b; logic bin; logic [N-1:0] d; logic bo, ov; } vec_t;

  int    checks = 0, errors = 0, dut_drn = 0;
  bit    rdy_en = 1'b0, last_acc = 1'b0;
  item_t q[$];
  vec_t  tv[8];

  function automatic res_t model(logic [N-1:0] x, logic [N-1:0] y, logic c);
    logic [N:0] t;
    int         s;
    res_t       r;
    t    = {1'b0, x} - {1'b0, y} - (N+1)'(c);
    s    = int'($signed(x)) - int'($signed(y)) - int'(c);
    r.d  = t[N-1:0];
    r.bo = t[N];
    r.ov = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h want=%0h @%0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic new_ops();
    a   = 16'($urandom);
    b   = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
    bin = 1'($urandom);
  endtask

  // One clock: check at negedge against the queue model, then advance the model at posedge.
  task automatic tick();
    logic  exp_rdy, exp_ov, drn;
    item_t it;
    @(negedge clk);
    exp_rdy = rdy_en && ((q.size() < 2) || out_ready);
    exp_ov  = (q.size() > 0) && (q[0].age >= 1);
    for (int k = 0; k < ND; k++) begin
      chk("in_ready", k, 32'(rdy[k]), 32'(exp_rdy));
      chk("out_valid", k, 32'(ov[k]), 32'(exp_ov));
      if (exp_ov) begin
        chk("diff", k, 32'(df[k]), 32'(q[0].r.d));
        chk("bout", k, 32'(bo[k]), 32'(q[0].r.bo));
        chk("ovf",  k, 32'(of[k]), 32'(q[0].r.ov));
      end
    end
    if (ov[0] && out_ready) dut_drn++;
    last_acc = in_valid && exp_rdy;
    drn      = exp_ov && out_ready;
    @(posedge clk);
    if (rst_n) begin
      rdy_en = 1'b1;
      if (drn) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (last_acc) begin
        it.r   = model(a, b, bin);
        it.age = 0;
        q.push_back(it);
      end
    end
    #1;
  endtask

  initial begin
    int nacc, d0;
    tv[0] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[1] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tv[2] = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0};
    tv[3] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[6] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
    tv[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_out_valid", k, 32'(ov[k]), 0);
      chk("rst_diff", k, 32'(df[k]), 0);
      chk("rst_bout", k, 32'(bo[k]), 0);
      chk("rst_ovf", k, 32'(of[k]), 0);
      chk("rst_in_ready", k, 32'(rdy[k]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < ND; k++) chk("rel_in_ready0", k, 32'(rdy[k]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) chk("rel_in_ready1", k, 32'(rdy[k]), 1);
    rdy_en = 1'b1;

    // Directed vectors with exact 2-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = tv[i].a; b = tv[i].b; bin = tv[i].bin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < ND; k++) chk("lat1_out_valid", k, 32'(ov[k]), 0);
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) begin
        chk("vec_out_valid", k, 32'(ov[k]), 1);
        chk("vec_diff", k, 32'(df[k]), 32'(tv[i].d));
        chk("vec_bout", k, 32'(bo[k]), 32'(tv[i].bo));
        chk("vec_ovf", k, 32'(of[k]), 32'(tv[i].ov));
      end
      @(posedge clk); #1;
    end

    // Backpressure: three operands offered, only two fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_ops();
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_acc) begin nacc++; new_ops(); end
    end
    chk("stall_accepts", 0, 32'(nacc), 2);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_acc) in_valid = 1'b0;
    end

    // Back-to-back random with no stalls
    in_valid = 1'b1;
    new_ops();
    d0 = dut_drn;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (last_acc) new_ops();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("b2b_results", 0, 32'(dut_drn - d0), 100);

    // Random valid and backpressure
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        new_ops();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_ops();
    tick(); new_ops();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) chk("midrst_out_valid", k, 32'(ov[k]), 0);
    q.delete();
    rdy_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
